// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU and
// ALUSrcB selector codes, FSM state encoding and the aggregated control word.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SRCB_W   = 2;

  // Primary opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;

  // ALU operation select
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_ADDI  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTI  = 3'b100;

  // ALU B operand select
  localparam logic [SRCB_W-1:0] SRCB_B       = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'b11;

  // FSM state encoding; codes 12..15 are unreachable and recover to FETCH
  typedef enum logic [STATE_W-1:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_BRANCH   = 4'd10,
    S_WB_I     = 4'd11
  } state_t;

  // Aggregated datapath control word driven each cycle
  typedef struct packed {
    logic                pc_write;
    logic                pc_write_cond;
    logic                pc_source;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mdr_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [SRCB_W-1:0]   alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_done;
    logic                illegal;
    logic                bus_err;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter with timeout detection.
//  clk_i, rst_i : clock, async active-low reset
//  clear        : zero the counter (state entry / timeout)
//  enable       : current state is waiting on the memory port
//  ready        : memory completes this cycle
//  timeout_c    : combinational, counter reached MEM_TIMEOUT with ready low
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic timeout_c
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               TO_EN   = (MEM_TIMEOUT != 0);

  logic [CNT_W-1:0] cnt;
  logic             wait_c;

  assign wait_c    = enable && !ready;
  assign timeout_c = TO_EN && wait_c && (cnt == LIMIT);

  // Counts stalled cycles; saturates so an unbounded wait never wraps
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (wait_c && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences a shared datapath through
// FETCH/DECODE/EXEC/MEM/WB for R-type, lw, sw, beq, addi and slti, waiting on
// a memory ready handshake with timeout and flagging illegal opcodes.
//  clk_i, rst_i        : clock, async active-low reset
//  instr_op_i          : IR[31:26], valid from DECODE onward
//  mem_ready_i         : memory completes current access
//  zero_i              : ALU zero flag (gated with PCWriteCond_o in datapath)
//  PCWrite_o .. ALU_op_o : datapath controls (combinational from state)
//  instr_done_o        : pulse on the last cycle of each instruction
//  illegal_o           : pulse on unknown opcode in DECODE
//  bus_err_o           : pulse on memory access timeout
//  state_o             : current state code
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                mem_ready_i,
  input  logic                zero_i,
  output logic                PCWrite_o,
  output logic                PCWriteCond_o,
  output logic                PCSource_o,
  output logic                IorD_o,
  output logic                MemRead_o,
  output logic                MemWrite_o,
  output logic                IRWrite_o,
  output logic                MDRWrite_o,
  output logic                RegDst_o,
  output logic                MemtoReg_o,
  output logic                RegWrite_o,
  output logic                ALUSrcA_o,
  output logic [SRCB_W-1:0]   ALUSrcB_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic                instr_done_o,
  output logic                illegal_o,
  output logic                bus_err_o,
  output logic [STATE_W-1:0]  state_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   tmr_enable;
  logic   tmr_clear;
  logic   mem_timeout;
  logic   unused_zero;

  // The branch decision is taken in the datapath from PCWriteCond_o & zero_i
  assign unused_zero = zero_i;

  // Only the memory-access states observe mem_ready_i
  assign tmr_enable = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR);
  // Restart the count on every state change and on a FETCH retry
  assign tmr_clear  = (state_d != state_q) || mem_timeout;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear     (tmr_clear),
    .enable    (tmr_enable),
    .ready     (mem_ready_i),
    .timeout_c (mem_timeout)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control word
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_read  = !mem_timeout;
        if (mem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (mem_timeout) begin
          // Retry the same PC; nothing was written
          ctrl.bus_err = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        case (instr_op_i)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_WB_R;
      end
      S_WB_R: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (instr_op_i == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
        state_d        = S_WB_I;
      end
      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (instr_op_i == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (instr_op_i == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = !mem_timeout;
        if (mem_ready_i) begin
          ctrl.mdr_write = 1'b1;
          state_d        = S_WB_MEM;
        end else if (mem_timeout) begin
          ctrl.bus_err = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_WB_MEM: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = !mem_timeout;
        if (mem_ready_i) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end else if (mem_timeout) begin
          ctrl.bus_err = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_done    = 1'b1;
        state_d            = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign PCWrite_o     = ctrl.pc_write;
  assign PCWriteCond_o = ctrl.pc_write_cond;
  assign PCSource_o    = ctrl.pc_source;
  assign IorD_o        = ctrl.iord;
  assign MemRead_o     = ctrl.mem_read;
  assign MemWrite_o    = ctrl.mem_write;
  assign IRWrite_o     = ctrl.ir_write;
  assign MDRWrite_o    = ctrl.mdr_write;
  assign RegDst_o      = ctrl.reg_dst;
  assign MemtoReg_o    = ctrl.mem_to_reg;
  assign RegWrite_o    = ctrl.reg_write;
  assign ALUSrcA_o     = ctrl.alu_src_a;
  assign ALUSrcB_o     = ctrl.alu_src_b;
  assign ALU_op_o      = ctrl.alu_op;
  assign instr_done_o  = ctrl.instr_done;
  assign illegal_o     = ctrl.illegal;
  assign bus_err_o     = ctrl.bus_err;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a driver applies one input vector per
// cycle and queues the hand-derived expected control word and state; a
// monitor pops and compares at every falling edge.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef logic [$bits(ctrl_t)+STATE_W-1:0] vec_t;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [OP_W-1:0]     instr_op_i;
  logic                mem_ready_i;
  logic                zero_i;
  logic                PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o;
  logic                MemRead_o, MemWrite_o, IRWrite_o, MDRWrite_o;
  logic                RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o;
  logic [SRCB_W-1:0]   ALUSrcB_o;
  logic [ALU_OP_W-1:0] ALU_op_o;
  logic                instr_done_o, illegal_o, bus_err_o;
  logic [STATE_W-1:0]  state_o;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  ctrl_t act_c;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i),
    .mem_ready_i(mem_ready_i), .zero_i(zero_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o),
    .PCSource_o(PCSource_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o), .MDRWrite_o(MDRWrite_o),
    .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o),
    .bus_err_o(bus_err_o), .state_o(state_o)
  );

  always_comb begin
    act_c               = '0;
    act_c.pc_write      = PCWrite_o;
    act_c.pc_write_cond = PCWriteCond_o;
    act_c.pc_source     = PCSource_o;
    act_c.iord          = IorD_o;
    act_c.mem_read      = MemRead_o;
    act_c.mem_write     = MemWrite_o;
    act_c.ir_write      = IRWrite_o;
    act_c.mdr_write     = MDRWrite_o;
    act_c.reg_dst       = RegDst_o;
    act_c.mem_to_reg    = MemtoReg_o;
    act_c.reg_write     = RegWrite_o;
    act_c.alu_src_a     = ALUSrcA_o;
    act_c.alu_src_b     = ALUSrcB_o;
    act_c.alu_op        = ALU_op_o;
    act_c.instr_done    = instr_done_o;
    act_c.illegal       = illegal_o;
    act_c.bus_err       = bus_err_o;
  end

  // Expected control words, written out from the state descriptions
  function automatic ctrl_t c_zero();
    ctrl_t c = '0;
    return c;
  endfunction
  function automatic ctrl_t c_fetch(input logic rdy, input logic berr);
    ctrl_t c = '0;
    c.mem_read = !berr; c.alu_src_b = 2'b01;
    c.ir_write = rdy;   c.pc_write = rdy; c.bus_err = berr;
    return c;
  endfunction
  function automatic ctrl_t c_decode(input logic ill);
    ctrl_t c = '0;
    c.alu_src_b = 2'b11; c.illegal = ill;
    return c;
  endfunction
  function automatic ctrl_t c_exec_r();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b010;
    return c;
  endfunction
  function automatic ctrl_t c_wb_r();
    ctrl_t c = '0;
    c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_exec_i(input logic [2:0] op);
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op;
    return c;
  endfunction
  function automatic ctrl_t c_wb_i();
    ctrl_t c = '0;
    c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_mem_addr();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctrl_t c_mem_rd(input logic rdy, input logic berr);
    ctrl_t c = '0;
    c.iord = 1'b1; c.mem_read = !berr; c.mdr_write = rdy; c.bus_err = berr;
    return c;
  endfunction
  function automatic ctrl_t c_wb_mem();
    ctrl_t c = '0;
    c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_mem_wr(input logic rdy, input logic berr);
    ctrl_t c = '0;
    c.iord = 1'b1; c.mem_write = !berr; c.instr_done = rdy; c.bus_err = berr;
    return c;
  endfunction
  function automatic ctrl_t c_branch();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b001;
    c.pc_write_cond = 1'b1; c.pc_source = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction

  // Apply one cycle of inputs and queue what the DUT must show this cycle
  task automatic step(input logic rst, input logic rdy, input logic [5:0] op,
                      input logic z, input ctrl_t c, input logic [3:0] st,
                      input string name);
    rst_i       = rst;
    mem_ready_i = rdy;
    instr_op_i  = op;
    zero_i      = z;
    exp_q.push_back({c, st});
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation at the falling edge
  initial begin
    vec_t  exp_v;
    vec_t  act_v;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {act_c, state_o};
        n_checks++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL %s @%0t: got ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                   nm, $time, act_v[STATE_W +: $bits(ctrl_t)], act_v[STATE_W-1:0],
                   exp_v[STATE_W +: $bits(ctrl_t)], exp_v[STATE_W-1:0]);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b0; mem_ready_i = 1'b1; instr_op_i = '0; zero_i = 1'b0;
    @(posedge clk);
    #1;
    // Reset held, then released
    for (int i = 0; i < 3; i++) step(0, 1, 6'h00, 0, c_zero(), 4'd0, "reset_hold");
    step(1, 1, 6'h00, 0, c_zero(), 4'd0, "reset_release");
    // R-type
    step(1, 1, 6'h00, 0, c_fetch(1, 0), 4'd1,  "r_fetch");
    step(1, 0, 6'h00, 0, c_decode(0),   4'd2,  "r_decode");
    step(1, 1, 6'h00, 0, c_exec_r(),    4'd7,  "r_exec");
    step(1, 0, 6'h00, 0, c_wb_r(),      4'd8,  "r_wb");
    // lw with three stall cycles
    step(1, 1, 6'h23, 0, c_fetch(1, 0), 4'd1,  "lw_fetch");
    step(1, 0, 6'h23, 0, c_decode(0),   4'd2,  "lw_decode");
    step(1, 1, 6'h23, 0, c_mem_addr(),  4'd3,  "lw_addr");
    for (int i = 0; i < 3; i++) step(1, 0, 6'h23, 0, c_mem_rd(0, 0), 4'd4, "lw_rd_wait");
    step(1, 1, 6'h23, 0, c_mem_rd(1, 0), 4'd4, "lw_rd_ready");
    step(1, 0, 6'h23, 0, c_wb_mem(),     4'd5, "lw_wb");
    // beq
    step(1, 1, 6'h04, 1, c_fetch(1, 0), 4'd1,  "beq_fetch");
    step(1, 1, 6'h04, 1, c_decode(0),   4'd2,  "beq_decode");
    step(1, 1, 6'h04, 1, c_branch(),    4'd10, "beq_branch");
    // addi, slti
    step(1, 1, 6'h08, 0, c_fetch(1, 0),     4'd1,  "addi_fetch");
    step(1, 1, 6'h08, 0, c_decode(0),       4'd2,  "addi_decode");
    step(1, 1, 6'h08, 0, c_exec_i(3'b011),  4'd9,  "addi_exec");
    step(1, 1, 6'h08, 0, c_wb_i(),          4'd11, "addi_wb");
    step(1, 1, 6'h0A, 0, c_fetch(1, 0),     4'd1,  "slti_fetch");
    step(1, 1, 6'h0A, 0, c_decode(0),       4'd2,  "slti_decode");
    step(1, 1, 6'h0A, 0, c_exec_i(3'b100),  4'd9,  "slti_exec");
    step(1, 1, 6'h0A, 0, c_wb_i(),          4'd11, "slti_wb");
    // sw, ready immediately
    step(1, 1, 6'h2B, 0, c_fetch(1, 0),  4'd1, "sw_fetch");
    step(1, 1, 6'h2B, 0, c_decode(0),    4'd2, "sw_decode");
    step(1, 1, 6'h2B, 0, c_mem_addr(),   4'd3, "sw_addr");
    step(1, 1, 6'h2B, 0, c_mem_wr(1, 0), 4'd6, "sw_wr_ready");
    // sw, ready arrives on the timeout cycle: ready wins
    step(1, 1, 6'h2B, 0, c_fetch(1, 0),  4'd1, "sw2_fetch");
    step(1, 1, 6'h2B, 0, c_decode(0),    4'd2, "sw2_decode");
    step(1, 1, 6'h2B, 0, c_mem_addr(),   4'd3, "sw2_addr");
    for (int i = 0; i < 4; i++) step(1, 0, 6'h2B, 0, c_mem_wr(0, 0), 4'd6, "sw2_wait");
    step(1, 1, 6'h2B, 0, c_mem_wr(1, 0), 4'd6, "sw2_ready_at_limit");
    // sw that times out: bus error, no done
    step(1, 1, 6'h2B, 0, c_fetch(1, 0),  4'd1, "sw3_fetch");
    step(1, 1, 6'h2B, 0, c_decode(0),    4'd2, "sw3_decode");
    step(1, 1, 6'h2B, 0, c_mem_addr(),   4'd3, "sw3_addr");
    for (int i = 0; i < 4; i++) step(1, 0, 6'h2B, 0, c_mem_wr(0, 0), 4'd6, "sw3_wait");
    step(1, 0, 6'h2B, 0, c_mem_wr(0, 1), 4'd6, "sw3_timeout");
    // Fetch timeout then retry, followed by an illegal opcode
    for (int i = 0; i < 4; i++) step(1, 0, 6'h3F, 0, c_fetch(0, 0), 4'd1, "fetch_wait");
    step(1, 0, 6'h3F, 0, c_fetch(0, 1), 4'd1, "fetch_timeout");
    step(1, 1, 6'h3F, 0, c_fetch(1, 0), 4'd1, "fetch_retry");
    step(1, 1, 6'h3F, 0, c_decode(1),   4'd2, "illegal_decode");
    step(1, 1, 6'h00, 0, c_fetch(1, 0), 4'd1, "after_illegal_fetch");
    step(1, 1, 6'h00, 0, c_decode(0),   4'd2, "r2_decode");
    step(1, 1, 6'h00, 0, c_exec_r(),    4'd7, "r2_exec");
    step(1, 1, 6'h00, 0, c_wb_r(),      4'd8, "r2_wb");
    // lw aborted by reset during MEM_RD
    step(1, 1, 6'h23, 0, c_fetch(1, 0),  4'd1, "lw2_fetch");
    step(1, 1, 6'h23, 0, c_decode(0),    4'd2, "lw2_decode");
    step(1, 1, 6'h23, 0, c_mem_addr(),   4'd3, "lw2_addr");
    step(1, 0, 6'h23, 0, c_mem_rd(0, 0), 4'd4, "lw2_rd_wait");
    step(0, 1, 6'h23, 0, c_zero(),       4'd0, "reset_mid_mem_rd");
    step(0, 1, 6'h23, 0, c_zero(),       4'd0, "reset_mid_hold");
    step(1, 1, 6'h00, 0, c_zero(),       4'd0, "reset_mid_release");
    step(1, 1, 6'h00, 0, c_fetch(1, 0),  4'd1, "restart_fetch");
    step(1, 1, 6'h00, 0, c_decode(0),    4'd2, "restart_decode");
    // Every queued expectation must have been consumed by the monitor
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
